// File: rtl/nic_fifo_out_buffer_pkg.sv
// Shared NIC definitions: sizing constants, flit-type encodings, FSM
// encoding and small helper functions used by the output buffer.
package nic_fifo_out_buffer_pkg;

  localparam int FLIT_WIDTH        = 16;
  localparam int MAX_PACKET_LENGHT = 5;
  localparam int N_OF_VN           = 2;
  localparam int N_OF_VC           = 2;
  localparam int MAX_CREDIT        = 2;

  // Flit type lives in the two low bits of every flit.
  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT_VA = 2'b01,
    ST_SEND    = 2'b10
  } state_e;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >>> 1;
    end
    return res;
  endfunction

  // Number of flits in a packet: position of the first tail or head-tail
  // flit plus one, or the full packet when no flit closes it. The scan runs
  // from the top down so the lowest closing flit is the one that sticks.
  function automatic int packet_length(
    input logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] pkt
  );
    int len;
    logic [1:0] ftype;
    len = MAX_PACKET_LENGHT;
    for (int k = MAX_PACKET_LENGHT - 1; k >= 0; k--) begin
      ftype = pkt[k*FLIT_WIDTH +: 2];
      if (ftype == FLIT_TAIL || ftype == FLIT_HEAD_TAIL) begin
        len = k + 1;
      end
    end
    return len;
  endfunction

endpackage

// File: rtl/nic_fifo_out_buffer_if.sv
// Bundle of packetizer, VC-allocator, link-allocator and credit signals
// around the NIC output buffer. The buffer uses the slave view; the
// surrounding environment drives it through the master view.
interface nic_fifo_out_buffer_if
  import nic_fifo_out_buffer_pkg::*;
#(
  parameter int N_BITS_VNET_ID = clog2(N_OF_VN),
  parameter int N_BITS_VC_ID   = N_OF_VC * N_OF_VN
) ();

  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] pkt_i;
  logic [N_BITS_VNET_ID-1:0]               vnet_id_i;
  logic                                    is_valid_i;
  logic                                    r_va_o;
  logic [N_BITS_VNET_ID-1:0]               vnet_id_o;
  logic                                    g_va_i;
  logic [N_BITS_VC_ID-1:0]                 vc_id_i;
  logic                                    r_la_o;
  logic [FLIT_WIDTH-1:0]                   flit_o;
  logic                                    is_valid_o;
  logic                                    g_la_i;
  logic                                    credit_in_i;
  logic                                    release_pointer_o;
  logic [N_BITS_VC_ID-1:0]                 vc_id_o;
  logic                                    free_slot_o;

  modport slave (
    input  pkt_i, vnet_id_i, is_valid_i, g_va_i, vc_id_i, g_la_i, credit_in_i,
    output r_va_o, vnet_id_o, r_la_o, flit_o, is_valid_o,
           release_pointer_o, vc_id_o, free_slot_o
  );

  modport master (
    output pkt_i, vnet_id_i, is_valid_i, g_va_i, vc_id_i, g_la_i, credit_in_i,
    input  r_va_o, vnet_id_o, r_la_o, flit_o, is_valid_o,
           release_pointer_o, vc_id_o, free_slot_o
  );

endinterface

// File: rtl/nic_fifo_out_buffer_credit_counter.sv
// Saturating credit counter for the held VC. A load restores the full
// credit budget; simultaneous inc and dec cancel out.
module nic_fifo_out_buffer_credit_counter #(
  parameter int WIDTH = 2,
  parameter int MAX   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  input  logic dec,
  output logic nonzero
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;

  // Next count: load wins, otherwise saturating increment or decrement.
  always_comb begin
    count_next_s = count_r;
    if (load) begin
      count_next_s = WIDTH'(MAX);
    end else if (inc && !dec) begin
      if (count_r != WIDTH'(MAX)) begin
        count_next_s = count_r + WIDTH'(1);
      end else begin
        count_next_s = count_r;
      end
    end else if (dec && !inc) begin
      if (count_r != {WIDTH{1'b0}}) begin
        count_next_s = count_r - WIDTH'(1);
      end else begin
        count_next_s = count_r;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Credit count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end

  assign nonzero = (count_r != {WIDTH{1'b0}});

endmodule

// File: rtl/nic_fifo_out_buffer.sv
// Single-packet NIC output buffer: holds one packet, obtains a VC, then
// streams flits under credit flow control and frees the VC after the tail.
module nic_fifo_out_buffer
  import nic_fifo_out_buffer_pkg::*;
#(
  parameter int N_BITS_VNET_ID       = clog2(N_OF_VN),
  parameter int N_BITS_VC_ID         = N_OF_VC * N_OF_VN,
  parameter int N_BITS_CREDIT        = clog2(MAX_CREDIT),
  parameter int N_BITS_PACKET_LENGHT = clog2(MAX_PACKET_LENGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  nic_fifo_out_buffer_if.slave  bus
);

  localparam int PKT_W = MAX_PACKET_LENGHT * FLIT_WIDTH;
  localparam int LEN_W = N_BITS_PACKET_LENGHT;

  state_e                    state_r;
  state_e                    state_next_s;
  logic [PKT_W-1:0]          pkt_r;
  logic [N_BITS_VNET_ID-1:0] vnet_r;
  logic [N_BITS_VC_ID-1:0]   vc_r;
  logic [LEN_W-1:0]          len_r;
  logic [LEN_W-1:0]          idx_r;
  logic [LEN_W-1:0]          len_s;
  logic [FLIT_WIDTH-1:0]     cur_flit_s;
  logic [FLIT_WIDTH-1:0]     flit_r;
  logic                      valid_r;
  logic                      release_r;
  logic                      accept_s;
  logic                      grant_s;
  logic                      send_s;
  logic                      last_s;
  logic                      credits_nz_s;

  assign len_s      = LEN_W'(packet_length(bus.pkt_i));
  assign cur_flit_s = pkt_r[int'(idx_r)*FLIT_WIDTH +: FLIT_WIDTH];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and per-cycle strobes; grants outside their state are ignored.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    grant_s      = 1'b0;
    send_s       = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.is_valid_i) begin
          accept_s     = 1'b1;
          state_next_s = ST_WAIT_VA;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_VA: begin
        if (bus.g_va_i) begin
          grant_s      = 1'b1;
          state_next_s = ST_SEND;
        end else begin
          state_next_s = ST_WAIT_VA;
        end
      end
      ST_SEND: begin
        if (bus.g_la_i && credits_nz_s) begin
          send_s = 1'b1;
          if (idx_r == (len_r - LEN_W'(1))) begin
            last_s       = 1'b1;
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_SEND;
          end
        end else begin
          state_next_s = ST_SEND;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Packet store, VC, flit index and registered flit/release outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_r     <= {PKT_W{1'b0}};
      vnet_r    <= {N_BITS_VNET_ID{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      vc_r      <= {N_BITS_VC_ID{1'b0}};
      idx_r     <= {LEN_W{1'b0}};
      flit_r    <= {FLIT_WIDTH{1'b0}};
      valid_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      valid_r   <= send_s;
      release_r <= last_s;
      if (accept_s) begin
        pkt_r  <= bus.pkt_i;
        vnet_r <= bus.vnet_id_i;
        len_r  <= len_s;
      end
      if (grant_s) begin
        vc_r  <= bus.vc_id_i;
        idx_r <= {LEN_W{1'b0}};
      end
      if (send_s) begin
        flit_r <= cur_flit_s;
        idx_r  <= idx_r + LEN_W'(1);
      end
    end
  end

  nic_fifo_out_buffer_credit_counter #(
    .WIDTH (N_BITS_CREDIT + 1),
    .MAX   (MAX_CREDIT)
  ) u_credit_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (grant_s),
    .inc     (bus.credit_in_i),
    .dec     (send_s),
    .nonzero (credits_nz_s)
  );

  // Request and status outputs are decoded from registered state only.
  assign bus.free_slot_o       = (state_r == ST_IDLE);
  assign bus.r_va_o            = (state_r == ST_WAIT_VA);
  assign bus.r_la_o            = (state_r == ST_SEND) && credits_nz_s;
  assign bus.vnet_id_o         = vnet_r;
  assign bus.vc_id_o           = vc_r;
  assign bus.flit_o            = flit_r;
  assign bus.is_valid_o        = valid_r;
  assign bus.release_pointer_o = release_r;

endmodule

// File: tb/tb_nic_fifo_out_buffer.sv
// Directed bench for the NIC output buffer: full five-flit packet with
// credit stalls, head-tail packet, ignored requests and mid-packet reset.
module tb_nic_fifo_out_buffer;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  localparam logic [79:0] PKT_A = 80'hFFF2_DDD1_CCC1_BBB1_0000;
  localparam logic [79:0] PKT_B = 80'h1111_2222_3332_4441_ABC3;

  nic_fifo_out_buffer_if bus ();

  nic_fifo_out_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_free"},    32'(bus.free_slot_o),       32'h1);
    check_eq({tag, "_r_va"},    32'(bus.r_va_o),            32'h0);
    check_eq({tag, "_r_la"},    32'(bus.r_la_o),            32'h0);
    check_eq({tag, "_valid"},   32'(bus.is_valid_o),        32'h0);
    check_eq({tag, "_flit"},    32'(bus.flit_o),            32'h0);
    check_eq({tag, "_vc"},      32'(bus.vc_id_o),           32'h0);
    check_eq({tag, "_release"}, 32'(bus.release_pointer_o), 32'h0);
    check_eq({tag, "_vnet"},    32'(bus.vnet_id_o),         32'h0);
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    clk             = 1'b0;
    rst             = 1'b1;
    bus.pkt_i       = 80'h0;
    bus.vnet_id_i   = 1'b0;
    bus.is_valid_i  = 1'b0;
    bus.g_va_i      = 1'b0;
    bus.vc_id_i     = 4'b0000;
    bus.g_la_i      = 1'b0;
    bus.credit_in_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check_reset_outputs("reset");

    // Accept the five-flit packet.
    bus.pkt_i      = PKT_A;
    bus.vnet_id_i  = 1'b0;
    bus.is_valid_i = 1'b1;
    step();
    bus.is_valid_i = 1'b0;
    check_eq("acc_free", 32'(bus.free_slot_o), 32'h0);
    check_eq("acc_r_va", 32'(bus.r_va_o),      32'h1);
    check_eq("acc_vnet", 32'(bus.vnet_id_o),   32'h0);
    check_eq("acc_r_la", 32'(bus.r_la_o),      32'h0);

    // VC grant.
    bus.g_va_i  = 1'b1;
    bus.vc_id_i = 4'b0001;
    step();
    bus.g_va_i  = 1'b0;
    bus.vc_id_i = 4'b0000;
    check_eq("va_r_va", 32'(bus.r_va_o),  32'h0);
    check_eq("va_r_la", 32'(bus.r_la_o),  32'h1);
    check_eq("va_vc",   32'(bus.vc_id_o), 32'h1);

    // Two flits use up both credits, the third grant is a stall.
    bus.g_la_i = 1'b1;
    step();
    check_eq("f0_flit",  32'(bus.flit_o),     32'h0000);
    check_eq("f0_valid", 32'(bus.is_valid_o), 32'h1);
    step();
    check_eq("f1_flit",  32'(bus.flit_o),     32'hBBB1);
    check_eq("f1_valid", 32'(bus.is_valid_o), 32'h1);
    check_eq("f1_r_la",  32'(bus.r_la_o),     32'h0);
    step();
    check_eq("stall0_valid", 32'(bus.is_valid_o), 32'h0);
    bus.g_la_i = 1'b0;

    // Three credits returned; the count must stop at two.
    bus.credit_in_i = 1'b1;
    step();
    check_eq("cr_r_la", 32'(bus.r_la_o), 32'h1);
    step();
    step();
    bus.credit_in_i = 1'b0;
    bus.g_la_i      = 1'b1;
    step();
    check_eq("f2_flit",  32'(bus.flit_o),     32'hCCC1);
    check_eq("f2_valid", 32'(bus.is_valid_o), 32'h1);
    step();
    check_eq("f3_flit",  32'(bus.flit_o),     32'hDDD1);
    check_eq("f3_r_la",  32'(bus.r_la_o),     32'h0);
    step();
    check_eq("stall1_valid", 32'(bus.is_valid_o), 32'h0);
    bus.g_la_i = 1'b0;

    // One credit, then the tail goes out with the release pulse.
    bus.credit_in_i = 1'b1;
    step();
    bus.credit_in_i = 1'b0;
    bus.g_la_i      = 1'b1;
    step();
    bus.g_la_i = 1'b0;
    check_eq("tail_flit",    32'(bus.flit_o),            32'hFFF2);
    check_eq("tail_valid",   32'(bus.is_valid_o),        32'h1);
    check_eq("tail_release", 32'(bus.release_pointer_o), 32'h1);
    check_eq("tail_vc",      32'(bus.vc_id_o),           32'h1);
    check_eq("tail_free",    32'(bus.free_slot_o),       32'h1);
    check_eq("tail_r_la",    32'(bus.r_la_o),            32'h0);
    step();
    check_eq("post_release", 32'(bus.release_pointer_o), 32'h0);
    check_eq("post_valid",   32'(bus.is_valid_o),        32'h0);

    // A VA grant while idle must not change the held VC.
    bus.g_va_i  = 1'b1;
    bus.vc_id_i = 4'b1000;
    step();
    bus.g_va_i  = 1'b0;
    bus.vc_id_i = 4'b0000;
    check_eq("idle_grant_vc",   32'(bus.vc_id_o), 32'h1);
    check_eq("idle_grant_r_va", 32'(bus.r_va_o),  32'h0);

    // Head-tail packet on vnet 1; a second offer while busy is ignored.
    bus.pkt_i      = PKT_B;
    bus.vnet_id_i  = 1'b1;
    bus.is_valid_i = 1'b1;
    step();
    bus.pkt_i      = PKT_A;
    bus.vnet_id_i  = 1'b0;
    step();
    bus.is_valid_i = 1'b0;
    check_eq("ht_vnet", 32'(bus.vnet_id_o), 32'h1);
    check_eq("ht_r_va", 32'(bus.r_va_o),    32'h1);
    bus.g_va_i  = 1'b1;
    bus.vc_id_i = 4'b0100;
    step();
    bus.g_va_i  = 1'b0;
    bus.vc_id_i = 4'b0000;
    check_eq("ht_vc", 32'(bus.vc_id_o), 32'h4);
    bus.g_la_i = 1'b1;
    step();
    bus.g_la_i = 1'b0;
    check_eq("ht_flit",    32'(bus.flit_o),            32'hABC3);
    check_eq("ht_valid",   32'(bus.is_valid_o),        32'h1);
    check_eq("ht_release", 32'(bus.release_pointer_o), 32'h1);
    check_eq("ht_free",    32'(bus.free_slot_o),       32'h1);
    step();
    check_eq("ht_post_valid", 32'(bus.is_valid_o), 32'h0);

    // Reset in the middle of sending a packet.
    bus.pkt_i      = PKT_A;
    bus.vnet_id_i  = 1'b1;
    bus.is_valid_i = 1'b1;
    step();
    bus.is_valid_i = 1'b0;
    bus.g_va_i     = 1'b1;
    bus.vc_id_i    = 4'b0010;
    step();
    bus.g_va_i     = 1'b0;
    bus.vc_id_i    = 4'b0000;
    bus.g_la_i     = 1'b1;
    step();
    check_eq("mid_flit",  32'(bus.flit_o),     32'h0000);
    check_eq("mid_valid", 32'(bus.is_valid_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    bus.g_la_i = 1'b0;
    step();
    rst = 1'b0;
    step();
    check_eq("after_rst_release", 32'(bus.release_pointer_o), 32'h0);
    check_eq("after_rst_free",    32'(bus.free_slot_o),       32'h1);
    check_eq("after_rst_r_va",    32'(bus.r_va_o),            32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nic_fifo_out_buffer.md
# nic_fifo_out_buffer

Single-packet output buffer on the NIC injection path. It accepts one whole packet from the packetizer and requests a virtual channel from the VC allocator (VA). After the grant it requests the link from the link allocator (LA) and emits the packet flit by flit under per-VC credit flow control. When the tail flit leaves, it releases the VC back to the FIFO-status-pointer block.

## Interface
Parameters:
- N_BITS_VNET_ID, default clog2(`N_OF_VN) = 1: virtual-network id width.
- N_BITS_VC_ID, default `N_OF_VC*`N_OF_VN = 4: one-hot VC id width.
- N_BITS_CREDIT, default clog2(`MAX_CREDIT) = 1: credit width. The internal counter is N_BITS_CREDIT+1 bits wide.
- N_BITS_PACKET_LENGHT, default clog2(`MAX_PACKET_LENGHT) = 3: flit index width.
- Global defines: `FLIT_WIDTH=16, `MAX_PACKET_LENGHT=5, `N_OF_VN=2, `N_OF_VC=2, `MAX_CREDIT=2.

Ports:
- clk  in  1  single clock; all flops on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pkt_i  in  `MAX_PACKET_LENGHT*`FLIT_WIDTH  packet; flit k occupies bits [k*FW+FW-1 : k*FW], with flit 0 = head.
- vnet_id_i  in  N_BITS_VNET_ID  vnet of the packet.
- is_valid_i  in  1  pkt_i/vnet_id_i are valid.
- r_va_o  out  1  VC allocation request.
- vnet_id_o  out  N_BITS_VNET_ID  stored vnet, presented to the VA.
- g_va_i  in  1  VA grant.
- vc_id_i  in  N_BITS_VC_ID  granted VC, one-hot.
- r_la_o  out  1  link request.
- flit_o  out  `FLIT_WIDTH  output flit.
- is_valid_o  out  1  flit_o is valid.
- g_la_i  in  1  LA grant.
- credit_in_i  in  1  one credit returned for the held VC.
- release_pointer_o  out  1  one-cycle pulse that frees the VC.
- vc_id_o  out  N_BITS_VC_ID  held VC.
- free_slot_o  out  1  buffer empty; a new packet can be accepted.

## Operation
- Flit type is held in flit[1:0]:
  - 00 = head
  - 01 = body
  - 10 = tail
  - 11 = head-tail
- Packet length is the index of the first flit with type 10 or 11, plus 1. If no flit has either type, the length is `MAX_PACKET_LENGHT.
- FSM states: IDLE → WAIT_VA → SEND → IDLE.
- IDLE:
  - free_slot_o=1.
  - If is_valid_i=1: latch pkt_i, vnet_id_i and the computed length; go to WAIT_VA.
- WAIT_VA:
  - r_va_o=1, vnet_id_o = stored vnet.
  - If g_va_i=1: latch vc_id_i, load credits = `MAX_CREDIT, set flit index = 0; go to SEND.
- SEND:
  - r_la_o = (credits != 0).
  - If g_la_i && r_la_o: register flit[index] onto flit_o, assert is_valid_o, index++, credits--.
  - If the flit just sent is the last one: go to IDLE and pulse release_pointer_o.
- Credits:
  - credit_in_i adds 1 in any state; the count saturates at `MAX_CREDIT.
  - Send and credit_in_i in the same cycle leave the count unchanged.
  - Credits arriving outside SEND are discarded, because the next grant reloads the count.
- Grants received when not requested (g_va_i outside WAIT_VA, g_la_i while r_la_o=0) are ignored.
- is_valid_i outside IDLE is ignored; the upstream block must check free_slot_o first.
- vc_id_o always equals the stored VC and holds its value after release until the next VA grant.

## Timing
- Reset values:
  - free_slot_o=1.
  - All other outputs 0.
  - FSM in IDLE; credits, index and stored data 0.
- Packet accepted at edge n → free_slot_o=0 and r_va_o=1 from n+1.
- VA grant at edge m → r_va_o=0 and r_la_o=1 from m+1.
- Link grant at edge k → flit_o and is_valid_o are valid during cycle k+1 only. Throughput is one flit per cycle while credits last.
- Tail sent at edge t, during cycle t+1:
  - is_valid_o=1 with the tail flit.
  - release_pointer_o=1 with vc_id_o.
  - free_slot_o=1 and r_la_o=0.
- A new packet can be accepted at edge t+1.
- Reset asserted mid-packet: the packet is dropped and every output returns immediately to its reset value. No release pulse is generated.

## Structure
- Shared NIC package/include holds:
  - the defines FLIT_WIDTH, MAX_PACKET_LENGHT, N_OF_VN, N_OF_VC, MAX_CREDIT;
  - the flit-type encodings (HEAD, BODY, TAIL, HEAD_TAIL);
  - the clog2 function.
- Sub-module credit_counter: saturating up/down counter with load, inc and dec inputs and a nonzero flag. Everything else stays flat.

## Test plan
- Reset, then send pkt 80'hFFF2DDD1CCC1BBB10000 with is_valid_i for one cycle. Required:
  - length 5;
  - free_slot_o=0;
  - r_va_o=1 the next cycle with vnet_id_o=0.
- g_va_i=1 with vc_id_i=4'b0001 for one cycle. Required: r_va_o drops, r_la_o=1, vc_id_o=0001.
- g_la_i high for 2 cycles. Required:
  - flit_o=0000 then BBB1, with is_valid_o=1 on each;
  - credits reach 0;
  - r_la_o=0, and a further g_la_i produces no flit.
- credit_in_i high for 3 cycles. Required: credits saturate at 2 and r_la_o=1. Then g_la_i for 3 cycles → CCC1, DDD1, then a stall while credit 0.
- One more credit, then g_la_i. Required:
  - flit_o=FFF2;
  - release_pointer_o pulse with vc_id_o=0001;
  - free_slot_o=1 the same cycle.
- Packet 80'h...0003 (head-tail at flit 0). Required: a single flit is sent, then release. Separately, assert rst during SEND → all outputs return to reset values and no release pulse is generated.
